mem_arbiter: RTL and testbench

Two-requester controller for the shared 11 x 8 register memory. Arbitrates round-robin between requesters, sequences each access into the memory's single-strobe `wr`/`rd` interface, and returns read data with a one-cycle acknowledge. Guarantees the memory never sees `wr` and `rd` together. It also rejects addresses beyond the memory depth without touching the array.

---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/mem_arbiter_rr_picker.sv | 25 ++
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared state encoding and default geometry for the two-requester memory arbiter.
package mem_arbiter_pkg;
    localparam int NREQ_DEF   = 2;
    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;
endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr (mod NREQ) wins.
// Zero latency; produces a one-hot winner plus a valid flag.
module rr_picker #(
    parameter int NREQ  = 2,
    parameter int PTR_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  winner,
    output logic             valid
);
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx    = '0;
        winner = '0;
        valid  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PTR_W'((int'(ptr) + i) % NREQ);
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin controller for the shared register memory: IDLE -> ACCESS -> RESP, one access per 3 cycles.
// Requesters hold req until ack; out-of-range addresses complete with err and never strobe the memory.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          ack,
    output logic                     err,
    output logic [DATA_W-1:0]        rdata,
    output logic                     busy,
    output logic                     mem_wr,
    output logic                     mem_rd,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_din,
    input  logic [DATA_W-1:0]        mem_dout
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    state_t              r_state;
    state_t              w_next;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    r_id;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_err;

    logic [NREQ-1:0]     w_winner;
    logic                w_pick_vld;
    logic [PTR_W-1:0]    w_win_id;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_sel_oob;

    rr_picker #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_winner),
        .valid  (w_pick_vld)
    );

    always_comb begin
        w_win_id    = '0;
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner[i]) begin
                w_win_id    = PTR_W'(i);
                w_sel_we    = req_we[i];
                w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_sel_oob = ({1'b0, w_sel_addr} >= DEPTH_L);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request fields are captured once in IDLE so later input changes cannot disturb the access.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_id    <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_vld) begin
                        r_id    <= w_win_id;
                        r_we    <= w_sel_we;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_err   <= w_sel_oob;
                    end
                end
                RESP: begin
                    if (r_id == PTR_W'(NREQ - 1)) begin
                        r_ptr <= '0;
                    end else begin
                        r_ptr <= r_id + PTR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        gnt    = '0;
        ack    = '0;
        err    = 1'b0;
        busy   = 1'b0;
        mem_wr = 1'b0;
        mem_rd = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_next = ACCESS;
                end
            end
            ACCESS: begin
                busy      = 1'b1;
                gnt[r_id] = 1'b1;
                if (!r_err) begin
                    mem_wr = r_we;
                    mem_rd = !r_we;
                end
                w_next = RESP;
            end
            RESP: begin
                busy      = 1'b1;
                ack[r_id] = 1'b1;
                err       = r_err;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign mem_addr = r_addr;
    assign mem_din  = r_wdata;
    assign rdata    = mem_dout;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 11 x 8 register memory attached.
module tb_mem_arbiter;
    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  req_we;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  gnt;
    logic [1:0]  ack;
    logic        err;
    logic [7:0]  rdata;
    logic        busy;
    logic        mem_wr;
    logic        mem_rd;
    logic [3:0]  mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;
    int both_hi = 0;

    logic [7:0] mem_arr [0:10];

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .ack       (ack),
        .err       (err),
        .rdata     (rdata),
        .busy      (busy),
        .mem_wr    (mem_wr),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            for (int i = 0; i < 11; i++) mem_arr[i] <= 8'h00;
            mem_dout <= 8'h00;
        end else begin
            if (mem_wr && mem_addr < 4'd11) mem_arr[mem_addr] <= mem_din;
            if (mem_rd && mem_addr < 4'd11) mem_dout <= mem_arr[mem_addr];
        end
    end

    always @(negedge clk) begin
        if (mem_wr) wr_pulses++;
        if (mem_rd) rd_pulses++;
        if (mem_wr && mem_rd) both_hi++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_access(input int k, input logic we, input logic [3:0] addr, input logic [7:0] wd,
                              output logic [1:0] g, output logic wr, output logic rd,
                              output logic [3:0] ma, output logic [7:0] md,
                              output logic [1:0] a, output logic e, output logic [7:0] rdat);
        @(posedge clk);
        #1;
        req_we[k]          = we;
        req_addr[k*4 +: 4] = addr;
        req_wdata[k*8 +: 8] = wd;
        req                = 2'b00;
        req[k]             = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (gnt !== 2'b00) break;
        end
        g = gnt; wr = mem_wr; rd = mem_rd; ma = mem_addr; md = mem_din;
        @(negedge clk);
        a = ack; e = err; rdat = rdata;
        req = 2'b00;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 2'b11; req_we = 2'b00; req_addr = 8'h00; req_wdata = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt_c1 got %b want 00", gnt); end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({gnt, ack, err, busy, mem_wr, mem_rd} !== 8'h00) begin
            errors++; $display("FAIL reset_ctrl got gnt=%b ack=%b err=%b busy=%b wr=%b rd=%b want all 0",
                                gnt, ack, err, busy, mem_wr, mem_rd);
        end
        checks++;
        if ({mem_addr, mem_din, rdata} !== 20'h0) begin
            errors++; $display("FAIL reset_data got addr=%h din=%h rdata=%h want 0", mem_addr, mem_din, rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (gnt !== 2'b01) begin errors++; $display("FAIL reset_first_gnt got %b want 01", gnt); end
        @(negedge clk);
        checks++;
        if (ack !== 2'b01) begin errors++; $display("FAIL reset_first_ack got %b want 01", ack); end
        req = 2'b00;
    endtask

    task automatic test_write_read;
        logic [1:0] g, a; logic wr, rd, e; logic [3:0] ma; logic [7:0] md, rdat;
        int rd0;
        run_access(0, 1'b1, 4'd3, 8'hA5, g, wr, rd, ma, md, a, e, rdat);
        checks++;
        if ({g, wr, rd} !== {2'b01, 1'b1, 1'b0}) begin
            errors++; $display("FAIL wr_access got gnt=%b wr=%b rd=%b want 01 1 0", g, wr, rd);
        end
        checks++;
        if ({ma, md} !== {4'd3, 8'hA5}) begin
            errors++; $display("FAIL wr_bus got addr=%h din=%h want 3 a5", ma, md);
        end
        checks++;
        if ({a, e} !== {2'b01, 1'b0}) begin errors++; $display("FAIL wr_ack got ack=%b err=%b want 01 0", a, e); end
        rd0 = rd_pulses;
        run_access(0, 1'b0, 4'd3, 8'h00, g, wr, rd, ma, md, a, e, rdat);
        checks++;
        if ({a, e, rdat} !== {2'b01, 1'b0, 8'hA5}) begin
            errors++; $display("FAIL rd_ack got ack=%b err=%b rdata=%h want 01 0 a5", a, e, rdat);
        end
        checks++;
        if (rd_pulses - rd0 !== 1) begin errors++; $display("FAIL rd_pulses got %0d want 1", rd_pulses - rd0); end
    endtask

    task automatic test_contention;
        logic [1:0] g, a; logic wr, rd, e; logic [3:0] ma; logic [7:0] md, rdat;
        logic [1:0] gseq [4];
        int gcyc [4];
        logic [1:0] exp_g;
        int n, b0;
        for (int i = 0; i < 4; i++) begin gseq[i] = 2'b00; gcyc[i] = 0; end
        // Requester 1 is served first so the pointer comes back to 0.
        run_access(1, 1'b0, 4'd0, 8'h00, g, wr, rd, ma, md, a, e, rdat);
        checks++;
        if (a !== 2'b10) begin errors++; $display("FAIL cont_pre_ack got %b want 10", a); end
        b0 = both_hi;
        @(posedge clk);
        #1;
        req_we = 2'b00; req_addr = 8'h00; req = 2'b11;
        n = 0;
        for (int i = 0; i < 30 && n < 4; i++) begin
            @(negedge clk);
            if (gnt !== 2'b00) begin gseq[n] = gnt; gcyc[n] = cyc; n++; end
        end
        @(negedge clk);
        req = 2'b00;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (gseq[i] !== exp_g) begin errors++; $display("FAIL cont_gnt%0d got %b want %b", i, gseq[i], exp_g); end
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (gcyc[i] - gcyc[i-1] !== 3) begin
                errors++; $display("FAIL cont_gap%0d got %0d want 3", i, gcyc[i] - gcyc[i-1]);
            end
        end
        checks++;
        if (both_hi - b0 !== 0) begin errors++; $display("FAIL cont_wr_and_rd got %0d want 0", both_hi - b0); end
    endtask

    task automatic test_out_of_range;
        logic [1:0] g, a; logic wr, rd, e; logic [3:0] ma; logic [7:0] md, rdat;
        int w0;
        for (int i = 0; i < 11; i++) begin
            run_access(0, 1'b1, 4'(i), 8'h10 + 8'(i), g, wr, rd, ma, md, a, e, rdat);
        end
        w0 = wr_pulses;
        run_access(1, 1'b1, 4'd12, 8'hFF, g, wr, rd, ma, md, a, e, rdat);
        checks++;
        if ({g, wr} !== {2'b10, 1'b0}) begin errors++; $display("FAIL oob12_access got gnt=%b wr=%b want 10 0", g, wr); end
        checks++;
        if ({a, e} !== {2'b10, 1'b1}) begin errors++; $display("FAIL oob12_ack got ack=%b err=%b want 10 1", a, e); end
        run_access(0, 1'b1, 4'd11, 8'hEE, g, wr, rd, ma, md, a, e, rdat);
        checks++;
        if ({a, e} !== {2'b01, 1'b1}) begin errors++; $display("FAIL oob11_ack got ack=%b err=%b want 01 1", a, e); end
        run_access(1, 1'b0, 4'd15, 8'h00, g, wr, rd, ma, md, a, e, rdat);
        checks++;
        if ({rd, a, e} !== {1'b0, 2'b10, 1'b1}) begin
            errors++; $display("FAIL oob15_rd got rd=%b ack=%b err=%b want 0 10 1", rd, a, e);
        end
        checks++;
        if (wr_pulses - w0 !== 0) begin errors++; $display("FAIL oob_wr_pulses got %0d want 0", wr_pulses - w0); end
        for (int i = 0; i < 11; i++) begin
            run_access(1, 1'b0, 4'(i), 8'h00, g, wr, rd, ma, md, a, e, rdat);
            checks++;
            if ({e, rdat} !== {1'b0, 8'h10 + 8'(i)}) begin
                errors++; $display("FAIL oob_readback%0d got err=%b rdata=%h want 0 %h", i, e, rdat, 8'h10 + 8'(i));
            end
        end
    endtask

    task automatic test_reset_mid_access;
        logic [1:0] ack_seen;
        @(posedge clk);
        #1;
        req_we[0] = 1'b1; req_addr[3:0] = 4'd7; req_wdata[7:0] = 8'h5A; req = 2'b01;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (gnt !== 2'b00) break;
        end
        rst = 1'b1;
        req = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ack_seen = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ack_seen = ack_seen | ack;
        end
        checks++;
        if (ack_seen !== 2'b00) begin errors++; $display("FAIL rstmid_ack got %b want 00", ack_seen); end
        // Both read addr 7: the pointer must be back at 0 and the array cleared.
        @(posedge clk);
        #1;
        req_we = 2'b00; req_addr = {4'd7, 4'd7}; req = 2'b11;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (gnt !== 2'b00) break;
        end
        checks++;
        if (gnt !== 2'b01) begin errors++; $display("FAIL rstmid_ptr got gnt=%b want 01", gnt); end
        @(negedge clk);
        req = 2'b00;
        checks++;
        if ({ack, err, rdata} !== {2'b01, 1'b0, 8'h00}) begin
            errors++; $display("FAIL rstmid_read got ack=%b err=%b rdata=%h want 01 0 00", ack, err, rdata);
        end
    endtask

    task automatic test_streaming;
        logic [7:0] wvals [2];
        int acyc [4];
        logic got;
        wvals[0] = 8'h3C; wvals[1] = 8'hC3;
        for (int i = 0; i < 4; i++) acyc[i] = 0;
        @(posedge clk);
        #1;
        req_addr[3:0] = 4'd10; req_we[0] = 1'b1; req_wdata[7:0] = wvals[0]; req = 2'b01;
        for (int op = 0; op < 4; op++) begin
            got = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (ack === 2'b01) begin got = 1'b1; break; end
            end
            acyc[op] = cyc;
            if (op % 2 == 1) begin
                checks++;
                if (!got || rdata !== wvals[op/2]) begin
                    errors++; $display("FAIL stream_rd%0d got ack_seen=%b rdata=%h want 1 %h", op, got, rdata, wvals[op/2]);
                end
                if (op < 3) begin req_we[0] = 1'b1; req_wdata[7:0] = wvals[(op+1)/2]; end
            end else begin
                req_we[0] = 1'b0;
            end
        end
        req = 2'b00;
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (acyc[i] - acyc[i-1] !== 3) begin
                errors++; $display("FAIL stream_gap%0d got %0d want 3", i, acyc[i] - acyc[i-1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_contention();
        test_out_of_range();
        test_reset_mid_access();
        test_streaming();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
